// File: rtl/fetch_request_arbiter.sv
// Collects per-wavefront fetch requests as pending bits and grants one wavefront ID per cycle
// to fetch, round-robin from the last granted ID, over a registered valid/ready slot.
module fetch_request_arbiter #(
  parameter int unsigned WF_PER_CU    = 40,
  parameter int unsigned WF_ID_LENGTH = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WF_PER_CU-1:0]    wave_valid_entries,
  input  logic                    dispatch_new_wf_en,
  input  logic [WF_ID_LENGTH-1:0] dispatch_new_wf_id,
  input  logic                    wf_halt_en,
  input  logic [WF_ID_LENGTH-1:0] wf_halt_id,
  output logic                    fetch_req_valid,
  output logic [WF_ID_LENGTH-1:0] fetch_req_wfid,
  input  logic                    fetch_req_ready,
  output logic [WF_PER_CU-1:0]    pending_bitmap,
  output logic                    dup_req_err
);

  localparam logic [WF_ID_LENGTH-1:0] LastId = WF_ID_LENGTH'(WF_PER_CU - 1);

  logic [WF_PER_CU-1:0]    pending_q, pending_d;
  logic                    valid_q, valid_d;
  logic [WF_ID_LENGTH-1:0] wfid_q, wfid_d;
  logic [WF_ID_LENGTH-1:0] ptr_q, ptr_d;
  logic                    dup_q, dup_d;

  logic [WF_PER_CU-1:0]    set_vec, halt_vec, slot_vec, above_ptr;
  logic [WF_PER_CU-1:0]    cand, cand_hi, load_vec;
  logic [WF_ID_LENGTH-1:0] hi_id, lo_id, pick_id;
  logic                    found_hi, slot_free, load;

  // Per-ID decode; IDs at or beyond WF_PER_CU match no bit and are ignored.
  always_comb begin
    set_vec   = '0;
    halt_vec  = '0;
    slot_vec  = '0;
    above_ptr = '0;
    for (int unsigned i = 0; i < WF_PER_CU; i++) begin
      set_vec[i]   = wave_valid_entries[i] |
                     (dispatch_new_wf_en & (dispatch_new_wf_id == WF_ID_LENGTH'(i)));
      halt_vec[i]  = wf_halt_en & (wf_halt_id == WF_ID_LENGTH'(i));
      slot_vec[i]  = valid_q & (wfid_q == WF_ID_LENGTH'(i));
      above_ptr[i] = WF_ID_LENGTH'(i) > ptr_q;
    end
  end

  // Round-robin pick: lowest candidate above ptr, else lowest overall (ptr itself comes last).
  always_comb begin
    cand     = pending_q & ~halt_vec;
    cand_hi  = cand & above_ptr;
    hi_id    = '0;
    lo_id    = '0;
    found_hi = 1'b0;
    for (int i = int'(WF_PER_CU) - 1; i >= 0; i--) begin
      if (cand_hi[i]) begin
        hi_id    = WF_ID_LENGTH'(i);
        found_hi = 1'b1;
      end
      if (cand[i]) begin
        lo_id = WF_ID_LENGTH'(i);
      end
    end
    pick_id = found_hi ? hi_id : lo_id;
  end

  always_comb begin
    slot_free = ~valid_q | fetch_req_ready;
    load      = slot_free & (|cand);
    load_vec  = load ? ({{(WF_PER_CU-1){1'b0}}, 1'b1} << pick_id) : '0;

    // Halt beats a new request, which beats the clear from a load of the same ID.
    pending_d = ~halt_vec & (set_vec | (pending_q & ~load_vec));

    dup_d = dup_q |
            (|(set_vec & (pending_q | (slot_vec & {WF_PER_CU{~fetch_req_ready}}))));

    valid_d = valid_q;
    wfid_d  = wfid_q;
    ptr_d   = ptr_q;
    if (load) begin
      valid_d = 1'b1;
      wfid_d  = pick_id;
      ptr_d   = pick_id;
    end else if (slot_free) begin
      valid_d = 1'b0;
    end else if (|(halt_vec & slot_vec)) begin
      // Only case where a presented request is withdrawn without ready.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
      valid_q   <= 1'b0;
      wfid_q    <= '0;
      ptr_q     <= LastId;
      dup_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      valid_q   <= valid_d;
      wfid_q    <= wfid_d;
      ptr_q     <= ptr_d;
      dup_q     <= dup_d;
    end
  end

  assign fetch_req_valid = valid_q;
  assign fetch_req_wfid  = wfid_q;
  assign pending_bitmap  = pending_q;
  assign dup_req_err     = dup_q;

endmodule

// File: tb/tb_fetch_request_arbiter.sv
// Directed and random stimulus for fetch_request_arbiter, checked every cycle against a
// per-ID array model of the pending/slot/round-robin rules.
module tb_fetch_request_arbiter;

  localparam int WF = 40;
  localparam int IDW = 6;

  logic           clk = 1'b0;
  logic           rst;
  logic [WF-1:0]  wave_valid_entries;
  logic           dispatch_new_wf_en;
  logic [IDW-1:0] dispatch_new_wf_id;
  logic           wf_halt_en;
  logic [IDW-1:0] wf_halt_id;
  logic           fetch_req_valid;
  logic [IDW-1:0] fetch_req_wfid;
  logic           fetch_req_ready;
  logic [WF-1:0]  pending_bitmap;
  logic           dup_req_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit m_pend [WF];
  bit m_valid;
  int m_id;
  int m_ptr;
  bit m_dup;

  fetch_request_arbiter #(.WF_PER_CU(WF), .WF_ID_LENGTH(IDW)) dut (
    .clk                (clk),
    .rst                (rst),
    .wave_valid_entries (wave_valid_entries),
    .dispatch_new_wf_en (dispatch_new_wf_en),
    .dispatch_new_wf_id (dispatch_new_wf_id),
    .wf_halt_en         (wf_halt_en),
    .wf_halt_id         (wf_halt_id),
    .fetch_req_valid    (fetch_req_valid),
    .fetch_req_wfid     (fetch_req_wfid),
    .fetch_req_ready    (fetch_req_ready),
    .pending_bitmap     (pending_bitmap),
    .dup_req_err        (dup_req_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WF-1:0] pend_vec();
    logic [WF-1:0] v = '0;
    for (int i = 0; i < WF; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic logic [WF-1:0] bits3(input int a, input int b, input int c);
    logic [WF-1:0] v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    if (c >= 0) v[c] = 1'b1;
    return v;
  endfunction

  function automatic logic [WF-1:0] rand_vec(input int unsigned one_in);
    logic [WF-1:0] v = '0;
    for (int i = 0; i < WF; i++) v[i] = ($urandom_range(0, one_in - 1) == 0);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < WF; i++) m_pend[i] = 1'b0;
    m_valid = 1'b0;
    m_id    = 0;
    m_ptr   = WF - 1;
    m_dup   = 1'b0;
  endtask

  // Advance the model by one clock edge given this cycle's inputs.
  task automatic model_step(input logic [WF-1:0] wv, input logic de, input int di,
                            input logic he, input int hi, input logic rdy);
    bit setb [WF];
    bit free;
    int pick;
    free = !m_valid || rdy;
    pick = -1;
    for (int k = 1; k <= WF; k++) begin
      int idx = (m_ptr + k) % WF;
      if (pick < 0 && m_pend[idx] && !(he && hi == idx)) pick = idx;
    end
    for (int i = 0; i < WF; i++) setb[i] = wv[i] || (de && di == i);
    for (int i = 0; i < WF; i++)
      if (setb[i] && (m_pend[i] || (m_valid && m_id == i && !rdy))) m_dup = 1'b1;
    for (int i = 0; i < WF; i++) begin
      if (he && hi == i)               m_pend[i] = 1'b0;
      else if (setb[i])                m_pend[i] = 1'b1;
      else if (free && pick == i)      m_pend[i] = 1'b0;
    end
    if (free && pick >= 0) begin
      m_valid = 1'b1;
      m_id    = pick;
      m_ptr   = pick;
    end else if (free) begin
      m_valid = 1'b0;
    end else if (he && hi == m_id) begin
      m_valid = 1'b0;
    end
  endtask

  // Drive one cycle: compare current outputs with the model, then clock both.
  task automatic step(input logic [WF-1:0] wv, input logic de, input int di,
                      input logic he, input int hi, input logic rdy);
    wave_valid_entries = wv;
    dispatch_new_wf_en = de;
    dispatch_new_wf_id = IDW'(di);
    wf_halt_en         = he;
    wf_halt_id         = IDW'(hi);
    fetch_req_ready    = rdy;
    chk("valid",   64'(fetch_req_valid), 64'(m_valid));
    chk("wfid",    64'(fetch_req_wfid),  64'(m_id));
    chk("pending", 64'(pending_bitmap),  64'(pend_vec()));
    chk("dup",     64'(dup_req_err),     64'(m_dup));
    model_step(wv, de, di, he, hi, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step('0, 1'b0, 0, 1'b0, 0, rdy);
  endtask

  task automatic set_idle_inputs();
    wave_valid_entries = '0;
    dispatch_new_wf_en = 1'b0;
    dispatch_new_wf_id = '0;
    wf_halt_en         = 1'b0;
    wf_halt_id         = '0;
    fetch_req_ready    = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_valid"},   64'(fetch_req_valid), 64'(0));
    chk({tag, "_wfid"},    64'(fetch_req_wfid),  64'(0));
    chk({tag, "_pending"}, 64'(pending_bitmap),  64'(0));
    chk({tag, "_dup"},     64'(dup_req_err),     64'(0));
  endtask

  task automatic do_reset();
    set_idle_inputs();
    rst = 1'b0;
    #2;
    check_reset_values("do_reset");
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    set_idle_inputs();
    model_reset();

    // Reset held with random inputs toggling
    for (int c = 0; c < 4; c++) begin
      wave_valid_entries = rand_vec(4);
      dispatch_new_wf_en = 1'($urandom_range(0, 1));
      dispatch_new_wf_id = IDW'($urandom_range(0, 63));
      wf_halt_en         = 1'($urandom_range(0, 1));
      wf_halt_id         = IDW'($urandom_range(0, 63));
      fetch_req_ready    = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check_reset_values("rst_hold");
    end
    set_idle_inputs();
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    step(bits3(0, -1, -1), 1'b0, 0, 1'b0, 0, 1'b1);
    idle(1'b1);
    chk("first_grant_valid", 64'(fetch_req_valid), 64'(1));
    chk("first_grant_wfid",  64'(fetch_req_wfid),  64'(0));
    idle(1'b1);

    // Single request: visible two cycles after the pulse, for one cycle only
    step(bits3(5, -1, -1), 1'b0, 0, 1'b0, 0, 1'b1);
    idle(1'b1);
    chk("single_valid", 64'(fetch_req_valid), 64'(1));
    chk("single_wfid",  64'(fetch_req_wfid),  64'(5));
    idle(1'b1);
    chk("single_gone", 64'(fetch_req_valid), 64'(0));

    // Round robin with wrap, from a fresh pointer
    do_reset();
    step(bits3(0, 1, 39), 1'b0, 0, 1'b0, 0, 1'b1);
    idle(1'b1);
    chk("rr0", 64'(fetch_req_wfid), 64'(0));
    idle(1'b1);
    chk("rr1", 64'(fetch_req_wfid), 64'(1));
    idle(1'b1);
    chk("rr39", 64'(fetch_req_wfid), 64'(39));
    step(bits3(38, 2, -1), 1'b0, 0, 1'b0, 0, 1'b1);
    idle(1'b1);
    chk("rr2", 64'(fetch_req_wfid), 64'(2));
    idle(1'b1);
    chk("rr38", 64'(fetch_req_wfid), 64'(38));
    idle(1'b1);

    // Backpressure with a duplicate request for the held ID
    step(bits3(7, -1, -1), 1'b0, 0, 1'b0, 0, 1'b1);
    idle(1'b0);
    idle(1'b0);
    step(bits3(7, -1, -1), 1'b0, 0, 1'b0, 0, 1'b0);
    chk("bp_dup", 64'(dup_req_err), 64'(1));
    idle(1'b0);
    idle(1'b0);
    chk("bp_valid", 64'(fetch_req_valid), 64'(1));
    chk("bp_wfid",  64'(fetch_req_wfid),  64'(7));
    idle(1'b1);
    chk("bp_regrant_valid", 64'(fetch_req_valid), 64'(1));
    chk("bp_regrant_wfid",  64'(fetch_req_wfid),  64'(7));
    idle(1'b1);

    // Halt withdraws the slot and beats a same-cycle request
    step(bits3(12, -1, -1), 1'b0, 0, 1'b0, 0, 1'b1);
    idle(1'b0);
    step(bits3(12, -1, -1), 1'b0, 0, 1'b1, 12, 1'b0);
    chk("halt_valid",  64'(fetch_req_valid),    64'(0));
    chk("halt_pend12", 64'(pending_bitmap[12]), 64'(0));
    idle(1'b1);
    step('0, 1'b1, 12, 1'b0, 0, 1'b1);
    idle(1'b1);
    chk("dispatch_valid", 64'(fetch_req_valid), 64'(1));
    chk("dispatch_wfid",  64'(fetch_req_wfid),  64'(12));
    idle(1'b1);

    // Asynchronous reset between edges
    do_reset();
    step(bits3(1, -1, -1), 1'b0, 0, 1'b0, 0, 1'b0);
    step(bits3(3, 9, 20), 1'b0, 0, 1'b0, 0, 1'b0);
    chk("mid_pending", 64'(pending_bitmap), 64'(bits3(3, 9, 20)));
    chk("mid_valid",   64'(fetch_req_valid), 64'(1));
    #3 rst = 1'b0;
    #1;
    check_reset_values("mid_rst");
    set_idle_inputs();
    model_reset();
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    step(bits3(0, -1, -1), 1'b0, 0, 1'b0, 0, 1'b1);
    idle(1'b1);
    chk("restart_wfid", 64'(fetch_req_wfid), 64'(0));

    // Random traffic including out-of-range IDs and halts of the held ID
    for (int c = 0; c < 400; c++) begin
      int hid;
      hid = ($urandom_range(0, 1) == 1) ? m_id : int'($urandom_range(0, 63));
      step(rand_vec(12), 1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 63)),
           1'($urandom_range(0, 5) == 0), hid, 1'($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
